// File: rtl/bldc_motion_counter.sv
// rtl/bldc_motion_counter.sv - windowed quadrature/hall step counter with saturating accumulators
// Inputs are synchronized, decoded into +1/0/-1 steps and published once per sample window.
module bldc_motion_counter #(
  parameter int ENCODER_COUNTER_WIDTH = 15,
  parameter int HALL_COUNTER_WIDTH    = 8,
  parameter int SAMPLE_CYCLES         = 18432
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enc_a,
  input  logic                             enc_b,
  input  logic [2:0]                       hall,
  output logic [ENCODER_COUNTER_WIDTH-1:0] enc_count,
  output logic [HALL_COUNTER_WIDTH-1:0]    hall_count,
  output logic                             enc_err,
  output logic                             hall_err,
  output logic                             count_valid
);

  localparam int EW = ENCODER_COUNTER_WIDTH;
  localparam int HW = HALL_COUNTER_WIDTH;
  localparam int CW = $clog2(SAMPLE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [EW-1:0] EMAX = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] EMIN = {1'b1, {(EW-1){1'b0}}};
  localparam logic [HW-1:0] HMAX = {1'b0, {(HW-1){1'b1}}};
  localparam logic [HW-1:0] HMIN = {1'b1, {(HW-1){1'b0}}};

  logic [1:0]    enc_s1, enc_s2, enc_prev;
  logic [2:0]    hall_s1, hall_s2, hall_prev;
  logic [1:0]    prime;
  logic [CW-1:0] win_cnt;
  logic [EW-1:0] acc_enc, enc_sum;
  logic [HW-1:0] acc_hall, hall_sum;
  logic          flag_enc, flag_hall;
  logic          decode_en;
  logic [1:0]    enc_diff;
  logic          enc_inc, enc_dec, enc_bad;
  logic          hall_inc, hall_dec, hall_bad;
  logic          hall_cur_ok, hall_prev_ok;

  // Forward successor in the hall sequence 1-3-2-6-4-5-1; invalid codes map to 0.
  function automatic logic [2:0] hall_next(input logic [2:0] h);
    case (h)
      3'd1:    hall_next = 3'd3;
      3'd3:    hall_next = 3'd2;
      3'd2:    hall_next = 3'd6;
      3'd6:    hall_next = 3'd4;
      3'd4:    hall_next = 3'd5;
      3'd5:    hall_next = 3'd1;
      default: hall_next = 3'd0;
    endcase
  endfunction

  always_comb begin
    decode_en    = (prime == 2'd0);
    enc_diff     = enc_s2 ^ enc_prev;
    enc_inc      = 1'b0;
    enc_dec      = 1'b0;
    enc_bad      = 1'b0;
    hall_inc     = 1'b0;
    hall_dec     = 1'b0;
    hall_bad     = 1'b0;
    hall_cur_ok  = (hall_s2 != 3'd0) && (hall_s2 != 3'd7);
    hall_prev_ok = (hall_prev != 3'd0) && (hall_prev != 3'd7);
    if (decode_en) begin
      // For a single-bit Gray step, prev A xor cur B gives the direction.
      if (enc_diff == 2'b11) begin
        enc_bad = 1'b1;
      end else if (enc_diff != 2'b00) begin
        if (enc_prev[1] ^ enc_s2[0]) enc_inc = 1'b1;
        else                         enc_dec = 1'b1;
      end
      if (!hall_cur_ok) begin
        hall_bad = 1'b1;
      end else if (hall_prev_ok && (hall_s2 != hall_prev)) begin
        if (hall_s2 == hall_next(hall_prev))      hall_inc = 1'b1;
        else if (hall_prev == hall_next(hall_s2)) hall_dec = 1'b1;
        else                                      hall_bad = 1'b1;
      end
    end
    enc_sum = acc_enc;
    if (enc_inc && (acc_enc != EMAX))      enc_sum = acc_enc + EW'(1);
    else if (enc_dec && (acc_enc != EMIN)) enc_sum = acc_enc - EW'(1);
    hall_sum = acc_hall;
    if (hall_inc && (acc_hall != HMAX))      hall_sum = acc_hall + HW'(1);
    else if (hall_dec && (acc_hall != HMIN)) hall_sum = acc_hall - HW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_s1      <= '0;
      enc_s2      <= '0;
      enc_prev    <= '0;
      hall_s1     <= '0;
      hall_s2     <= '0;
      hall_prev   <= '0;
      prime       <= 2'd3;
      win_cnt     <= RELOAD;
      acc_enc     <= '0;
      acc_hall    <= '0;
      flag_enc    <= 1'b0;
      flag_hall   <= 1'b0;
      enc_count   <= '0;
      hall_count  <= '0;
      enc_err     <= 1'b0;
      hall_err    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      enc_s1      <= {enc_a, enc_b};
      enc_s2      <= enc_s1;
      enc_prev    <= enc_s2;
      hall_s1     <= hall;
      hall_s2     <= hall_s1;
      hall_prev   <= hall_s2;
      count_valid <= 1'b0;
      if (prime != 2'd0) prime <= prime - 2'd1;
      if (win_cnt == '0) begin
        // Terminal cycle: publish including this cycle's step, then start a fresh window.
        enc_count   <= enc_sum;
        hall_count  <= hall_sum;
        enc_err     <= flag_enc | enc_bad;
        hall_err    <= flag_hall | hall_bad;
        count_valid <= 1'b1;
        acc_enc     <= '0;
        acc_hall    <= '0;
        flag_enc    <= 1'b0;
        flag_hall   <= 1'b0;
        win_cnt     <= RELOAD;
      end else begin
        acc_enc   <= enc_sum;
        acc_hall  <= hall_sum;
        flag_enc  <= flag_enc | enc_bad;
        flag_hall <= flag_hall | hall_bad;
        win_cnt   <= win_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bldc_motion_counter.sv
// tb/tb_bldc_motion_counter.sv - bench for bldc_motion_counter
// Two DUTs (encoder width 15 and 6) share stimulus and are checked against one window model.
module tb_bldc_motion_counter;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_a, enc_b;
  logic [2:0]  hall;
  logic [14:0] enc_count;
  logic [7:0]  hall_count;
  logic        enc_err, hall_err, count_valid;
  logic [5:0]  enc_count6;
  logic [7:0]  hall_count6;
  logic        enc_err6, hall_err6, count_valid6;

  int n_checks = 0;
  int n_fail   = 0;

  bldc_motion_counter #(.ENCODER_COUNTER_WIDTH(15), .HALL_COUNTER_WIDTH(8), .SAMPLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .hall(hall),
    .enc_count(enc_count), .hall_count(hall_count), .enc_err(enc_err),
    .hall_err(hall_err), .count_valid(count_valid)
  );

  bldc_motion_counter #(.ENCODER_COUNTER_WIDTH(6), .HALL_COUNTER_WIDTH(8), .SAMPLE_CYCLES(N)) dut6 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .hall(hall),
    .enc_count(enc_count6), .hall_count(hall_count6), .enc_err(enc_err6),
    .hall_err(hall_err6), .count_valid(count_valid6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int qpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int hpos(input logic [2:0] h);
    case (h)
      3'd1:    return 0;
      3'd3:    return 1;
      3'd2:    return 2;
      3'd6:    return 3;
      3'd4:    return 4;
      3'd5:    return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  int          e = 0;
  logic [1:0]  qe[$];
  logic [2:0]  qh[$];
  int          acc15 = 0, acc6 = 0, acch = 0;
  bit          wee = 0, whe = 0;
  int          m_enc = 0, m_enc6 = 0, m_hall = 0, m_ee = 0, m_he = 0, m_valid = 0;

  always @(posedge clk) begin
    int  de, dh, pp, pc;
    bit  ee, he;
    #1;
    if (reset) begin
      e = 0;
      qe.delete();
      qh.delete();
      acc15 = 0; acc6 = 0; acch = 0; wee = 0; whe = 0;
      m_enc = 0; m_enc6 = 0; m_hall = 0; m_ee = 0; m_he = 0; m_valid = 0;
    end else begin
      e++;
      qe.push_back({enc_a, enc_b});
      qh.push_back(hall);
      if (qe.size() > 4) begin
        void'(qe.pop_front());
        void'(qh.pop_front());
      end
      de = 0; dh = 0; ee = 0; he = 0;
      // A sample taken at edge k is credited at edge k+2; the first three edges are dead.
      if (e >= 4) begin
        pp = qpos(qe[qe.size()-4]);
        pc = qpos(qe[qe.size()-3]);
        case ((pc - pp + 4) % 4)
          1:       de = 1;
          3:       de = -1;
          2:       ee = 1;
          default: de = 0;
        endcase
        pp = hpos(qh[qh.size()-4]);
        pc = hpos(qh[qh.size()-3]);
        if (pc < 0) he = 1;
        else if (pp >= 0 && pp != pc) begin
          if ((pc - pp + 6) % 6 == 1)      dh = 1;
          else if ((pp - pc + 6) % 6 == 1) dh = -1;
          else                             he = 1;
        end
      end
      if (e % N == 0) begin
        m_enc   = sat(acc15 + de, 15);
        m_enc6  = sat(acc6 + de, 6);
        m_hall  = sat(acch + dh, 8);
        m_ee    = int'(wee | ee);
        m_he    = int'(whe | he);
        m_valid = 1;
        acc15 = 0; acc6 = 0; acch = 0; wee = 0; whe = 0;
      end else begin
        acc15   = sat(acc15 + de, 15);
        acc6    = sat(acc6 + de, 6);
        acch    = sat(acch + dh, 8);
        wee     = wee | ee;
        whe     = whe | he;
        m_valid = 0;
      end
    end
    chk("count_valid", int'(count_valid), m_valid);
    chk("enc_count", int'($signed(enc_count)), m_enc);
    chk("hall_count", int'($signed(hall_count)), m_hall);
    chk("enc_err", int'(enc_err), m_ee);
    chk("hall_err", int'(hall_err), m_he);
    chk("count_valid6", int'(count_valid6), m_valid);
    chk("enc_count6", int'($signed(enc_count6)), m_enc6);
    chk("hall_count6", int'($signed(hall_count6)), m_hall);
    chk("enc_err6", int'(enc_err6), m_ee);
    chk("hall_err6", int'(hall_err6), m_he);
  end

  // ---------------- stimulus ----------------
  localparam int K_IDLE = 0, K_FWD40 = 1, K_REV40 = 2, K_HREV = 3, K_HFWD = 4, K_ILL = 5;
  localparam int K_FWD3 = 6, K_HGAP = 7, K_HJUMP = 8, K_TERM = 9, K_REV7 = 10, K_RAND = 11;

  logic [1:0] gray_t [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [2:0] hall_t [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};
  int e_pos = 0;
  int h_idx = 0;

  task automatic enc_step(input int dir);
    e_pos = (e_pos + dir + 4) % 4;
    {enc_a, enc_b} = gray_t[e_pos];
  endtask

  task automatic enc_set(input logic [1:0] v);
    {enc_a, enc_b} = v;
    for (int k = 0; k < 4; k++) if (gray_t[k] == v) e_pos = k;
  endtask

  task automatic hall_step(input int dir);
    h_idx = (h_idx + dir + 6) % 6;
    hall = hall_t[h_idx];
  endtask

  task automatic hall_set(input logic [2:0] v);
    hall = v;
    for (int k = 0; k < 6; k++) if (hall_t[k] == v) h_idx = k;
  endtask

  task automatic drive(input int kind, input int i);
    int r;
    case (kind)
      K_FWD40: if (i >= 10 && i <= 166 && (i - 10) % 4 == 0) enc_step(1);
      K_REV40: if (i >= 10 && i <= 166 && (i - 10) % 4 == 0) enc_step(-1);
      K_HREV:  if (i % 20 == 0 && i <= 120) hall_step(-1);
      K_HFWD:  if (i % 20 == 0 && i <= 120) hall_step(1);
      K_ILL: begin
        if (i == 10) enc_set(~{enc_a, enc_b});
        else if (i >= 20 && i <= 50 && i % 10 == 0) enc_step(1);
      end
      K_FWD3:  if (i == 10 || i == 14 || i == 18) enc_step(1);
      K_HGAP: begin
        if (i == 20) hall_set(3'd3);
        if (i == 40) hall_set(3'd0);
        if (i == 60) hall_set(3'd2);
        if (i == 80) hall_set(3'd6);
      end
      K_HJUMP: begin
        if (i == 20) hall_set(3'd1);
        if (i == 40) hall_set(3'd6);
      end
      K_TERM:  if (i == 254) enc_step(1);
      K_REV7:  if (i >= 10 && i <= 34 && (i - 10) % 4 == 0) enc_step(-1);
      K_RAND: begin
        r = $urandom_range(0, 99);
        if (r < 15)      enc_step(($urandom_range(0, 1) == 1) ? 1 : -1);
        else if (r < 18) enc_set(2'($urandom_range(0, 3)));
        r = $urandom_range(0, 99);
        if (r < 5)       hall_step(($urandom_range(0, 1) == 1) ? 1 : -1);
        else if (r < 7)  hall_set(3'($urandom_range(0, 7)));
      end
      default: ;
    endcase
  endtask

  task automatic window(input int kind);
    for (int i = 1; i <= N; i++) begin
      drive(kind, i);
      @(negedge clk);
    end
  endtask

  task automatic lit(input string name, input int ec, input int ec6, input int hc, input int ee, input int he);
    chk({name, "_valid"}, int'(count_valid), 1);
    chk({name, "_enc"}, int'($signed(enc_count)), ec);
    chk({name, "_enc6"}, int'($signed(enc_count6)), ec6);
    chk({name, "_hall"}, int'($signed(hall_count)), hc);
    chk({name, "_enc_err"}, int'(enc_err), ee);
    chk({name, "_hall_err"}, int'(hall_err), he);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    hall  = 3'd1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_enc", int'($signed(enc_count)), 0);
    chk("rst_hall", int'($signed(hall_count)), 0);
    reset = 1'b0;

    window(K_FWD40); lit("fwd40", 40, 31, 0, 0, 0);
    window(K_IDLE);  lit("idle", 0, 0, 0, 0, 0);
    window(K_REV40); lit("rev40", -40, -32, 0, 0, 0);
    window(K_HREV);  lit("hrev", 0, 0, -6, 0, 0);
    window(K_HFWD);  lit("hfwd", 0, 0, 6, 0, 0);
    window(K_ILL);   lit("ill", 4, 4, 0, 1, 0);
    window(K_FWD3);  lit("clean", 3, 3, 0, 0, 0);
    window(K_HGAP);  lit("hgap", 0, 0, 2, 0, 1);
    window(K_HJUMP); lit("hjump", 0, 0, 0, 0, 1);
    window(K_TERM);  lit("term", 1, 1, 0, 0, 0);

    // Reset 100 cycles into a window holding 12 counted edges.
    for (int i = 1; i < 100; i++) begin
      if (i >= 10 && i <= 54 && (i - 10) % 4 == 0) enc_step(1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_enc", int'($signed(enc_count)), 0);
    chk("midrst_valid", int'(count_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    window(K_REV7);  lit("postrst", -7, -7, 0, 0, 0);

    // Reset lands on the terminal edge: no strobe.
    for (int i = 1; i < N; i++) begin
      if (i == 10 || i == 14 || i == 18) enc_step(1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("termrst_valid", int'(count_valid), 0);
    chk("termrst_enc", int'($signed(enc_count)), 0);
    reset = 1'b0;
    window(K_IDLE);  lit("after_termrst", 0, 0, 0, 0, 0);

    repeat (8) window(K_RAND);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bldc_motion_counter.md
Name: bldc_motion_counter

Overview:
- Producer side of the BLDC encoder/hall fault-check interface.
- Synchronizes raw quadrature encoder (A/B) and 3-bit hall sensor inputs, then decodes direction and step events.
- Accumulates signed counts over a fixed sample window and presents windowed enc_count/hall_count with a valid strobe.
- The encoder checker and the speed loop consume these counts once per window.

Parameters:
- ENCODER_COUNTER_WIDTH, 15: width of signed encoder count output and accumulator.
- HALL_COUNTER_WIDTH, 8: width of signed hall count output and accumulator.
- SAMPLE_CYCLES, 18432: clock cycles per sample window (1 kHz at 18.432 MHz); legal range ≥ 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enc_a  input  1  encoder channel A, asynchronous.
- enc_b  input  1  encoder channel B, asynchronous.
- hall  input  3  hall sensors {H3,H2,H1}, asynchronous.
- enc_count  output  ENCODER_COUNTER_WIDTH  signed encoder steps in the last completed window.
- hall_count  output  HALL_COUNTER_WIDTH  signed hall steps in the last completed window.
- enc_err  output  1  last window contained an illegal encoder transition.
- hall_err  output  1  last window contained an illegal hall state or transition.
- count_valid  output  1  one-cycle pulse when the outputs update.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clk and reset.
- Reset values:
  - enc_count=0, hall_count=0, enc_err=0, hall_err=0, count_valid=0.
  - Accumulators=0, window-error flags=0.
  - Window counter = SAMPLE_CYCLES-1.
- Synchronizers: 2-flop synchronizer on each of enc_a, enc_b and hall[2:0], followed by one previous-value register per signal.
- Latency: input edge to accumulator update is 3 clk.
- Prime: decode is disabled for 3 cycles after reset deasserts. Previous-value registers still load during prime, so no spurious step is counted.
- Quadrature decode, x4, on {A,B} previous→current:
  - 00→01→11→10→00 = +1; the reverse sequence = -1.
  - No change = 0.
  - Both bits changed = illegal: delta 0, set window enc_err flag.
- Hall decode:
  - Valid states are 1..6; forward sequence is 1→3→2→6→4→5→1 = +1, reverse = -1.
  - Same state = 0.
  - Current state 0 or 7: delta 0, flag error.
  - Valid→valid non-adjacent jump: delta 0, flag error.
  - Invalid→valid: delta 0, no error; previous register simply re-references.
- Accumulation:
  - Signed add of delta, saturating at the width's min/max (e.g. +16383/-16384 at width 15).
  - No wrap-around.
- Window counter:
  - Decrements every cycle after reset, including during prime.
  - At terminal (counter==0), in the same cycle:
    - enc_count ← sat(acc_enc + delta_enc) and hall_count ← sat(acc_hall + delta_hall); the terminal-cycle delta is included, so no edge is lost.
    - enc_err/hall_err ← window flag OR this cycle's error.
    - count_valid ← 1 for exactly one cycle.
    - Accumulators and window flags clear to 0.
    - Counter reloads SAMPLE_CYCLES-1.
- First count_valid occurs SAMPLE_CYCLES cycles after reset deasserts.
- Outputs hold between strobes.
- Reset mid-window: the partial window is discarded, outputs clear, and the window restarts.
- Reset asserted on a terminal cycle: reset wins and no strobe is produced.

Test Plan:
- SAMPLE_CYCLES=256: 10 forward quadrature cycles (40 edges, 4 clk apart), starting at cycle 10 → first strobe at cycle 256 with enc_count=+40, enc_err=0; next window enc_count=0.
- Hall reverse 1→5→4→6→2→3→1 (6 steps, 20 clk apart) → hall_count=-6, hall_err=0; the same sequence forward → +6.
- ENCODER_COUNTER_WIDTH=6, 40 forward edges → enc_count=+31 (saturated); 40 reverse edges → -32.
- A and B toggled in the same cycle once, plus 4 legal forward edges → enc_count=+4, enc_err=1; following clean window → enc_err=0.
- Hall 1→3→0→2→6 → hall_count=+2 (only 1→3 and 2→6 count), hall_err=1. Jump 1→6 → hall_count=0, hall_err=1.
- Edge landing exactly on the terminal cycle is counted in that window. Reset pulsed at cycle 100 of a window with 12 edges already counted → outputs 0, next strobe at 256 cycles after reset release, reflecting post-reset edges only.
